// File: rtl/micro_alpha_veryl_uart_line_receiver.sv
// 8N1 UART receiver feeding a circular line buffer; bytes become visible only once a CR commits the line.
// Optional build macro MICRO_ALPHA_VERYL_UART_LINE_RX_LF_DROP_EN drops received 0x0A bytes before the buffer.
module micro_alpha_veryl_uart_line_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       empty,
  input  logic       re,
  output logic       line_end,
  output logic       ovf,
  output logic       ferr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST_CLK = TW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] FULL_OCC = PW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [7:0] CR = 8'h0D;

  logic          rx_meta;
  logic          rxs;
  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rx_done;
  logic          rx_good;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] cm_ptr;
  logic [PW-1:0] rd_ptr;
  logic          discard;
  logic [7:0]    mem [DEPTH];

  logic [PW-1:0] occ;
  logic          lf_drop;
  logic          good;
  logic          is_cr;
  logic          wr_en;
  logic          full_hit;

  // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rx_done <= 1'b0;
      rx_good <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          if (!rxs) state <= S_START;
        end
        S_START: begin
          if (timer == HALF_BIT) begin
            timer <= '0;
            state <= rxs ? S_IDLE : S_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DATA: begin
          if (timer == LAST_CLK) begin
            timer   <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          if (timer == LAST_CLK) begin
            timer   <= '0;
            rx_done <= 1'b1;
            rx_good <= rxs;
            state   <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

`ifdef MICRO_ALPHA_VERYL_UART_LINE_RX_LF_DROP_EN
  assign lf_drop = (shreg == 8'h0A);
`else
  assign lf_drop = 1'b0;
`endif

  // The full test is against rd_ptr so uncommitted bytes can never overrun committed ones.
  always_comb begin
    occ      = wr_ptr - rd_ptr;
    good     = rx_done && rx_good && !lf_drop;
    is_cr    = (shreg == CR);
    wr_en    = 1'b0;
    full_hit = 1'b0;
    if (good && !discard) begin
      if (occ < FULL_OCC) wr_en    = 1'b1;
      else                full_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      cm_ptr  <= '0;
      rd_ptr  <= '0;
      discard <= 1'b0;
      ovf     <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      ovf  <= full_hit;
      ferr <= rx_done && !rx_good;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (is_cr) cm_ptr <= wr_ptr + PW'(1);
      end else if (full_hit) begin
        wr_ptr  <= cm_ptr;
        discard <= !is_cr;
      end else if (good && discard && is_cr) begin
        discard <= 1'b0;
      end
      if (re && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // NOTE: the byte store has no reset; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  assign empty    = (cm_ptr == rd_ptr);
  assign dout     = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign line_end = !empty && (dout == CR);

endmodule

// File: tb/tb_micro_alpha_veryl_uart_line_receiver.sv
// Directed bench for the UART line receiver: framing, commit-on-CR, overflow, framing error, glitch and reset.
module tb_micro_alpha_veryl_uart_line_receiver;

  localparam int CPB   = 8;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] dout;
  logic       empty;
  logic       re;
  logic       line_end;
  logic       ovf;
  logic       ferr;

  int checks;
  int errors;
  int ovf_cnt;
  int ferr_cnt;

  micro_alpha_veryl_uart_line_receiver #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rxd     (rxd),
    .dout    (dout),
    .empty   (empty),
    .re      (re),
    .line_end(line_end),
    .ovf     (ovf),
    .ferr    (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ovf)  ovf_cnt  = ovf_cnt + 1;
    if (ferr) ferr_cnt = ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one frame starting at a falling clock edge; returns at the falling edge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
  endtask

  task automatic idle(input int bits);
    rxd = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic pop(input logic [7:0] exp, input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'(exp));
    check({tag, "_line_end"}, 32'(line_end), 32'(exp == 8'h0D));
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic pop_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) pop(s[i], $sformatf("%s_%0d", tag, i));
    check({tag, "_drained"}, 32'(empty), 32'd1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    ovf_cnt  = 0;
    ferr_cnt = 0;
    rst      = 1'b1;
    rxd      = 1'b1;
    re       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_line_end", 32'(line_end), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    rst = 1'b0;
    idle(2);

    // Line invisible until the CR is written one edge after its stop sample.
    send_str("6 2 +");
    check("t1_no_cr_empty", 32'(empty), 32'd1);
    send_frame(8'h0D, 1'b1);
    check("t1_stop_edge_empty", 32'(empty), 32'd1);
    @(negedge clk);
    check("t1_commit_empty", 32'(empty), 32'd0);
    idle(1);
    pop_str("6 2 +\x0D", "t1");
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    check("t1_re_while_empty", 32'(empty), 32'd1);
    check("t1_re_while_empty_dout", 32'(dout), 32'h00);

    // Fourteen bytes buffered without reads.
    send_str("6 2 + 3 1 - *\x0D");
    idle(1);
    check("t2_ovf", 32'(ovf_cnt), 32'd0);
    pop_str("6 2 + 3 1 - *\x0D", "t2");

    // Seventeen non-CR bytes overflow; the next CR only clears the discard state.
    for (int i = 0; i < 17; i++) send_frame(8'h61 + 8'(i), 1'b1);
    idle(1);
    check("t3_ovf_once", 32'(ovf_cnt), 32'd1);
    check("t3_empty_after_ovf", 32'(empty), 32'd1);
    send_str("\x0D1\x0D");
    idle(1);
    check("t3_ovf_total", 32'(ovf_cnt), 32'd1);
    pop_str("1\x0D", "t3");

    // Bad stop bit drops the byte.
    send_frame(8'h41, 1'b0);
    idle(2);
    check("t4_ferr_once", 32'(ferr_cnt), 32'd1);
    check("t4_empty", 32'(empty), 32'd1);
    send_str("A\x0D");
    idle(1);
    check("t4_ferr_total", 32'(ferr_cnt), 32'd1);
    pop_str("A\x0D", "t4");

    // Short low glitch rejected at the start-bit midpoint.
    rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    idle(2);
    check("t5_glitch_empty", 32'(empty), 32'd1);
    check("t5_glitch_ferr", 32'(ferr_cnt), 32'd1);
    check("t5_glitch_ovf", 32'(ovf_cnt), 32'd1);
    send_str("x\x0D");
    idle(1);
    pop_str("x\x0D", "t5");

    // Reset mid-frame discards the partial line.
    send_str("12");
    rxd = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t6_rst_empty", 32'(empty), 32'd1);
    check("t6_rst_dout", 32'(dout), 32'h00);
    idle(2);
    send_str("9\x0D\x0A");
    idle(1);
    check("t6_ferr", 32'(ferr_cnt), 32'd1);
    pop_str("9\x0D", "t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
